dmem_byte_arbiter: RTL and testbench

- Two-port arbiter and sequencer for the byte-wide data memory (8-bit locations, 32 bytes by default).
- Serves 32-bit word reads and writes from two requesters: the CPU datapath port and a debug/loader port.
- Each word access runs as four consecutive big-endian byte beats on one single-port memory.
- Lets a test loader fill or inspect data memory without the simulator reading initialisation files directly.

---
 rtl/dmem_byte_arbiter.sv | 242 ++++++++++++++++++++++++
 tb/tb_dmem_byte_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_byte_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_byte_arbiter
//  Description : Two-port arbiter and sequencer for a byte-wide, single-port,
//                synchronous data memory. Each 32-bit word access from the
//                CPU port or the debug/loader port runs as four big-endian
//                byte beats (MSB at the lowest address). Ties between the two
//                ports are broken round-robin.
//  Ports       : clk, rst_n             clock / async active-low reset
//                cpu_* (req, we, addr, wdata -> ack, rdata)   CPU word port
//                dbg_* (req, we, addr, wdata -> ack, rdata)   debug word port
//                mem_en, mem_we, mem_addr, mem_wdata, mem_rdata
//                                       byte memory interface (1-cycle read)
//                busy                   high whenever a transfer is active
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_byte_arbiter #(
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic              cpu_ack,
   output logic [31:0]       cpu_rdata,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [31:0]       dbg_wdata,
   output logic              dbg_ack,
   output logic [31:0]       dbg_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      XFER   = 2'd1,
      RDLAST = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DBG = 1'b1;

   // Big-endian byte k of a word: k = 0 is bits [31:24].
   function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] k);
      logic [7:0] b;
      case (k)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      return b;
   endfunction

   function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] k,
                                            input logic [7:0] b);
      logic [31:0] r;
      r = w;
      case (k)
         2'd0:    r[31:24] = b;
         2'd1:    r[23:16] = b;
         2'd2:    r[15:8]  = b;
         default: r[7:0]   = b;
      endcase
      return r;
   endfunction

   state_t              state_q, state_d;
   logic [1:0]          beat_q, beat_d;
   logic                owner_q, owner_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [31:0]         cap_q, cap_d;
   logic                last_grant_q, last_grant_d;
   logic [31:0]         cpu_rdata_q, cpu_rdata_d;
   logic [31:0]         dbg_rdata_q, dbg_rdata_d;
   logic                cpu_ack_q, cpu_ack_d;
   logic                dbg_ack_q, dbg_ack_d;
   logic                mem_en_q, mem_en_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [7:0]          mem_wdata_q, mem_wdata_d;
   logic                busy_q, busy_d;

   logic                grant_dbg;
   logic                sel_we;
   logic [ADDR_W-1:0]   sel_addr;
   logic [31:0]         sel_wdata;
   logic [1:0]          next_beat;
   logic [31:0]         final_word;

   // All outputs are registered: the _d values below describe what the
   // memory/requester interfaces see in the cycle after the current edge.
   always_comb begin
      state_d      = state_q;
      beat_d       = beat_q;
      owner_d      = owner_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      cap_d        = cap_q;
      last_grant_d = last_grant_q;
      cpu_rdata_d  = cpu_rdata_q;
      dbg_rdata_d  = dbg_rdata_q;
      cpu_ack_d    = 1'b0;
      dbg_ack_d    = 1'b0;
      mem_en_d     = 1'b0;
      mem_we_d     = 1'b0;
      mem_addr_d   = '0;
      mem_wdata_d  = '0;

      // DBG wins only if CPU is absent or CPU was granted last time.
      grant_dbg  = dbg_req && (!cpu_req || (last_grant_q == OWN_CPU));
      sel_we     = grant_dbg ? dbg_we    : cpu_we;
      sel_addr   = grant_dbg ? dbg_addr  : cpu_addr;
      sel_wdata  = grant_dbg ? dbg_wdata : cpu_wdata;
      next_beat  = beat_q + 2'd1;
      final_word = put_byte(cap_q, 2'd3, mem_rdata);

      case (state_q)
         IDLE: begin
            if (cpu_req || dbg_req) begin
               owner_d      = grant_dbg ? OWN_DBG : OWN_CPU;
               last_grant_d = grant_dbg ? OWN_DBG : OWN_CPU;
               we_d         = sel_we;
               addr_d       = sel_addr;
               wdata_d      = sel_wdata;
               beat_d       = 2'd0;
               state_d      = XFER;
               // Beat 0 is presented straight from the accepted request.
               mem_en_d     = 1'b1;
               mem_we_d     = sel_we;
               mem_addr_d   = sel_addr;
               mem_wdata_d  = get_byte(sel_wdata, 2'd0);
            end
         end

         XFER: begin
            // Read data of beat k-1 is on mem_rdata while beat k is issued.
            if (!we_q && (beat_q != 2'd0)) begin
               cap_d = put_byte(cap_q, beat_q - 2'd1, mem_rdata);
            end
            if (beat_q == 2'd3) begin
               if (we_q) begin
                  state_d   = DONE;
                  cpu_ack_d = (owner_q == OWN_CPU);
                  dbg_ack_d = (owner_q == OWN_DBG);
               end else begin
                  state_d   = RDLAST;
               end
            end else begin
               beat_d      = next_beat;
               mem_en_d    = 1'b1;
               mem_we_d    = we_q;
               mem_addr_d  = addr_q + ADDR_W'(next_beat);
               mem_wdata_d = get_byte(wdata_q, next_beat);
            end
         end

         RDLAST: begin
            // LSB arrives now; publish the whole word as DONE is entered.
            cap_d     = final_word;
            state_d   = DONE;
            cpu_ack_d = (owner_q == OWN_CPU);
            dbg_ack_d = (owner_q == OWN_DBG);
            if (owner_q == OWN_CPU) begin
               cpu_rdata_d = final_word;
            end else begin
               dbg_rdata_d = final_word;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         beat_q       <= 2'd0;
         owner_q      <= OWN_CPU;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         cap_q        <= '0;
         last_grant_q <= OWN_DBG;   // so CPU wins the first tie
         cpu_rdata_q  <= '0;
         dbg_rdata_q  <= '0;
         cpu_ack_q    <= 1'b0;
         dbg_ack_q    <= 1'b0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         beat_q       <= beat_d;
         owner_q      <= owner_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         cap_q        <= cap_d;
         last_grant_q <= last_grant_d;
         cpu_rdata_q  <= cpu_rdata_d;
         dbg_rdata_q  <= dbg_rdata_d;
         cpu_ack_q    <= cpu_ack_d;
         dbg_ack_q    <= dbg_ack_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         busy_q       <= busy_d;
      end
   end

   assign cpu_ack   = cpu_ack_q;
   assign dbg_ack   = dbg_ack_q;
   assign cpu_rdata = cpu_rdata_q;
   assign dbg_rdata = dbg_rdata_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_byte_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_byte_arbiter
//  Description : Directed self-checking bench for dmem_byte_arbiter with a
//                32-byte synchronous byte memory model attached.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_byte_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [4:0]  cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic        cpu_ack;
   logic [31:0] cpu_rdata;
   logic        dbg_req = 1'b0, dbg_we = 1'b0;
   logic [4:0]  dbg_addr = '0;
   logic [31:0] dbg_wdata = '0;
   logic        dbg_ack;
   logic [31:0] dbg_rdata;
   logic        mem_en, mem_we;
   logic [4:0]  mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata = '0;
   logic        busy;

   logic [7:0]  tb_mem [0:31];
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   dmem_byte_arbiter #(.ADDR_W(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   // Synchronous single-port byte memory: read data valid the cycle after.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) tb_mem[mem_addr] <= mem_wdata;
         else        mem_rdata <= tb_mem[mem_addr];
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #3;
      n_checks++;
      if ({busy, cpu_ack, dbg_ack, mem_en} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {busy, cpu_ack, dbg_ack, mem_en});
      end
      n_checks++;
      if ({cpu_rdata, dbg_rdata} !== 64'h0) begin
         n_fail++; $display("FAIL reset_rdata: got %h/%h expected 0/0", cpu_rdata, dbg_rdata);
      end
      step(); step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_cpu_write();
      logic [31:0] w;
      w = 32'h11223344;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd4; cpu_wdata = w;
      for (int n = 1; n <= 6; n++) begin
         step();
         if (n <= 4) begin
            n_checks++;
            if ({mem_en, mem_we, mem_addr, mem_wdata, cpu_ack} !==
                {1'b1, 1'b1, 5'(3 + n), w[39-8*n -: 8], 1'b0}) begin
               n_fail++; $display("FAIL cpu_write_beat%0d: got en=%b we=%b a=%0d d=%h ack=%b expected 1 1 %0d %h 0",
                                  n - 1, mem_en, mem_we, mem_addr, mem_wdata, cpu_ack, 3 + n, w[39-8*n -: 8]);
            end
         end else begin
            n_checks++;
            if ({mem_en, cpu_ack, dbg_ack, busy} !== ((n == 5) ? 4'b0101 : 4'b0000)) begin
               n_fail++; $display("FAIL cpu_write_cycle%0d: got en/cack/dack/busy=%b expected %b",
                                  n, {mem_en, cpu_ack, dbg_ack, busy}, (n == 5) ? 4'b0101 : 4'b0000);
            end
            if (n == 5) cpu_req = 1'b0;
         end
      end
      n_checks++;
      if ({tb_mem[4], tb_mem[5], tb_mem[6], tb_mem[7]} !== 32'h11223344) begin
         n_fail++; $display("FAIL cpu_write_mem: got %h%h%h%h expected 11223344",
                            tb_mem[4], tb_mem[5], tb_mem[6], tb_mem[7]);
      end
   endtask

   task automatic test_cpu_read();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd4; cpu_wdata = 32'hFFFF_FFFF;
      for (int n = 1; n <= 7; n++) begin
         step();
         if (n <= 4) begin
            n_checks++;
            if ({mem_en, mem_we, mem_addr, cpu_ack} !== {1'b1, 1'b0, 5'(3 + n), 1'b0}) begin
               n_fail++; $display("FAIL cpu_read_beat%0d: got en=%b we=%b a=%0d ack=%b expected 1 0 %0d 0",
                                  n - 1, mem_en, mem_we, mem_addr, cpu_ack, 3 + n);
            end
         end else if (n == 5) begin
            n_checks++;
            if ({mem_en, cpu_ack, busy, cpu_rdata} !== {3'b001, 32'h0}) begin
               n_fail++; $display("FAIL cpu_read_rdlast: got en/ack/busy=%b rdata=%h expected 001 00000000",
                                  {mem_en, cpu_ack, busy}, cpu_rdata);
            end
         end else if (n == 6) begin
            n_checks++;
            if ({cpu_ack, dbg_ack, cpu_rdata} !== {2'b10, 32'h11223344}) begin
               n_fail++; $display("FAIL cpu_read_done: got ack=%b%b rdata=%h expected 10 11223344",
                                  cpu_ack, dbg_ack, cpu_rdata);
            end
            cpu_req = 1'b0;
         end else begin
            n_checks++;
            if ({cpu_ack, busy, dbg_rdata, cpu_rdata} !== {2'b00, 32'h0, 32'h11223344}) begin
               n_fail++; $display("FAIL cpu_read_after: got ack=%b busy=%b dbg_rdata=%h cpu_rdata=%h expected 0 0 0 11223344",
                                  cpu_ack, busy, dbg_rdata, cpu_rdata);
            end
         end
      end
   endtask

   task automatic test_contention();
      // Fresh reset: memory keeps its contents, the arbiter forgets history.
      rst_n = 1'b0; step(); rst_n = 1'b1; step();
      n_checks++;
      if ({cpu_rdata, dbg_rdata} !== 64'h0) begin
         n_fail++; $display("FAIL contention_reset_rdata: got %h/%h expected 0/0", cpu_rdata, dbg_rdata);
      end
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd4;  cpu_wdata = 32'h0;
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd12; dbg_wdata = 32'h55667788;
      for (int n = 1; n <= 20; n++) begin
         step();
         n_checks++;
         if ({cpu_ack, dbg_ack} !== {(n == 6 || n == 19), (n == 12)}) begin
            n_fail++; $display("FAIL contention_ack_c%0d: got cpu/dbg=%b%b expected %b%b",
                               n, cpu_ack, dbg_ack, (n == 6 || n == 19), (n == 12));
         end
         if (n == 1 || n == 14) begin
            n_checks++;
            if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 5'd4}) begin
               n_fail++; $display("FAIL contention_cpu_grant_c%0d: got en=%b we=%b a=%0d expected 1 0 4",
                                  n, mem_en, mem_we, mem_addr);
            end
         end
         if (n == 8) begin
            n_checks++;
            if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 5'd12, 8'h55}) begin
               n_fail++; $display("FAIL contention_dbg_grant: got en=%b we=%b a=%0d d=%h expected 1 1 12 55",
                                  mem_en, mem_we, mem_addr, mem_wdata);
            end
         end
         if (n == 6 || n == 19) begin
            n_checks++;
            if (cpu_rdata !== 32'h11223344) begin
               n_fail++; $display("FAIL contention_cpu_rdata_c%0d: got %h expected 11223344", n, cpu_rdata);
            end
         end
         if (n == 19) begin
            cpu_req = 1'b0; dbg_req = 1'b0;
         end
      end
      n_checks++;
      if ({busy, dbg_rdata, tb_mem[12], tb_mem[13], tb_mem[14], tb_mem[15]} !== {1'b0, 32'h0, 32'h55667788}) begin
         n_fail++; $display("FAIL contention_end: got busy=%b dbg_rdata=%h mem12=%h%h%h%h expected 0 0 55667788",
                            busy, dbg_rdata, tb_mem[12], tb_mem[13], tb_mem[14], tb_mem[15]);
      end
   endtask

   task automatic test_wrap();
      logic [4:0] exp_a;
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd30; dbg_wdata = 32'hAABBCCDD;
      for (int n = 1; n <= 5; n++) begin
         step();
         exp_a = (n == 1) ? 5'd30 : (n == 2) ? 5'd31 : (n == 3) ? 5'd0 : 5'd1;
         if (n <= 4) begin
            n_checks++;
            if ({mem_en, mem_we, mem_addr} !== {2'b11, exp_a}) begin
               n_fail++; $display("FAIL wrap_beat%0d: got en=%b we=%b a=%0d expected 1 1 %0d",
                                  n - 1, mem_en, mem_we, mem_addr, exp_a);
            end
         end else begin
            n_checks++;
            if (dbg_ack !== 1'b1) begin
               n_fail++; $display("FAIL wrap_write_ack: got %b expected 1", dbg_ack);
            end
            dbg_req = 1'b0;
         end
      end
      step();
      n_checks++;
      if ({tb_mem[30], tb_mem[31], tb_mem[0], tb_mem[1]} !== 32'hAABBCCDD) begin
         n_fail++; $display("FAIL wrap_mem: got %h%h%h%h expected aabbccdd",
                            tb_mem[30], tb_mem[31], tb_mem[0], tb_mem[1]);
      end
      dbg_req = 1'b1; dbg_we = 1'b0;
      for (int n = 1; n <= 6; n++) step();
      n_checks++;
      if ({dbg_ack, dbg_rdata, cpu_rdata} !== {1'b1, 32'hAABBCCDD, 32'h11223344}) begin
         n_fail++; $display("FAIL wrap_read: got ack=%b dbg_rdata=%h cpu_rdata=%h expected 1 aabbccdd 11223344",
                            dbg_ack, dbg_rdata, cpu_rdata);
      end
      dbg_req = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd8; cpu_wdata = 32'hCAFEF00D;
      step(); step(); step();
      n_checks++;
      if ({mem_en, mem_addr} !== {1'b1, 5'd10}) begin
         n_fail++; $display("FAIL midrst_beat2: got en=%b a=%0d expected 1 10", mem_en, mem_addr);
      end
      rst_n = 1'b0; cpu_req = 1'b0;
      #1;
      n_checks++;
      if ({mem_en, busy, cpu_ack} !== 3'b000) begin
         n_fail++; $display("FAIL midrst_immediate: got en/busy/ack=%b expected 000", {mem_en, busy, cpu_ack});
      end
      for (int n = 0; n < 2; n++) begin
         step();
         n_checks++;
         if ({mem_en, cpu_ack, dbg_ack} !== 3'b000) begin
            n_fail++; $display("FAIL midrst_hold%0d: got en/cack/dack=%b expected 000", n, {mem_en, cpu_ack, dbg_ack});
         end
      end
      rst_n = 1'b1;
      step();
      n_checks++;
      if ({tb_mem[8], tb_mem[9], tb_mem[10], tb_mem[11]} !== 32'hCAFE8A8B) begin
         n_fail++; $display("FAIL midrst_mem: got %h%h%h%h expected cafe8a8b",
                            tb_mem[8], tb_mem[9], tb_mem[10], tb_mem[11]);
      end
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd8;
      for (int n = 1; n <= 6; n++) begin
         step();
         if (n == 5) begin
            n_checks++;
            if (dbg_ack !== 1'b0) begin
               n_fail++; $display("FAIL midrst_read_early_ack: got %b expected 0", dbg_ack);
            end
         end
      end
      n_checks++;
      if ({dbg_ack, dbg_rdata, cpu_rdata} !== {1'b1, 32'hCAFE8A8B, 32'h0}) begin
         n_fail++; $display("FAIL midrst_read: got ack=%b dbg_rdata=%h cpu_rdata=%h expected 1 cafe8a8b 0",
                            dbg_ack, dbg_rdata, cpu_rdata);
      end
      dbg_req = 1'b0;
      step();
   endtask

   initial begin
      for (int i = 0; i < 32; i++) tb_mem[i] = 8'h80 | 8'(i);
      test_reset();
      test_cpu_write();
      test_cpu_read();
      test_contention();
      test_wrap();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
